// File: rtl/time_disp_scan.sv
// HH.MM.SS scan driver for a 6-digit multiplexed 7-segment display.
// Binary fields are snapshotted, converted to BCD by shift-add-3, then committed in one step to the scan buffer.
module time_disp_scan #(
  parameter int DIGIT_HOLD    = 1,
  parameter bit BLANK_LEAD_HR = 1'b1
) (
  input  logic       kh_clk,
  input  logic       reset,
  input  logic [4:0] hr,
  input  logic [5:0] min,
  input  logic [5:0] sec,
  output logic [5:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       upd
);

  // state    | meaning
  // C_IDLE   | waiting for the start of a scan frame
  // C_LOAD   | snapshot hr/min/sec, preload hour field
  // C_SHIFT  | 6 shift-add-3 steps per field, three fields back to back
  // C_COMMIT | shadow digits -> display buffer, pulse upd
  typedef enum logic [1:0] {C_IDLE, C_LOAD, C_SHIFT, C_COMMIT} cstate_t;

  localparam int HW = (DIGIT_HOLD > 1) ? $clog2(DIGIT_HOLD) : 1;
  localparam logic [3:0] DASH = 4'hA;

  cstate_t     state_q, state_d;
  logic [HW-1:0] hold_q;
  logic [2:0]  idx_q;
  logic [1:0]  field_q;
  logic [2:0]  bit_q;
  logic [12:0] sh_q;
  logic [5:0]  min_s_q, sec_s_q;
  logic [2:0]  oor_q;
  logic [3:0]  shad_q [6];
  logic [3:0]  disp_q [6];
  logic [5:0]  an_q;
  logic [6:0]  seg_q;
  logic        dp_q, upd_q;

  logic        start;
  logic [3:0]  units_a;
  logic [12:0] sh_next;
  logic [5:0]  next_bin;
  logic [3:0]  dig;

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;
  assign upd = upd_q;

  assign start = (idx_q == 3'd0) && (hold_q == '0) && (state_q == C_IDLE);

  // Tens never exceeds 3 before a shift for 6-bit inputs, so only units need the +3 correction.
  assign units_a  = (sh_q[9:6] >= 4'd5) ? sh_q[9:6] + 4'd3 : sh_q[9:6];
  assign sh_next  = {sh_q[11:10], units_a, sh_q[5:0], 1'b0};
  assign next_bin = (field_q == 2'd0) ? min_s_q : sec_s_q;
  assign dig      = disp_q[idx_q];

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    seg_code = 7'b1000000;
      4'd1:    seg_code = 7'b1111001;
      4'd2:    seg_code = 7'b0100100;
      4'd3:    seg_code = 7'b0110000;
      4'd4:    seg_code = 7'b0011001;
      4'd5:    seg_code = 7'b0010010;
      4'd6:    seg_code = 7'b0000010;
      4'd7:    seg_code = 7'b1111000;
      4'd8:    seg_code = 7'b0000000;
      4'd9:    seg_code = 7'b0010000;
      DASH:    seg_code = 7'b0111111;
      default: seg_code = 7'b1111111;
    endcase
  endfunction

  always_ff @(posedge kh_clk) begin
    if (reset) state_q <= C_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      C_IDLE:   if (start) state_d = C_LOAD;
      C_LOAD:   state_d = C_SHIFT;
      C_SHIFT:  if (bit_q == 3'd5 && field_q == 2'd2) state_d = C_COMMIT;
      C_COMMIT: state_d = C_IDLE;
      default:  state_d = C_IDLE;
    endcase
  end

  always_ff @(posedge kh_clk) begin
    if (reset) begin
      an_q    <= 6'b111111;
      seg_q   <= 7'h7F;
      dp_q    <= 1'b1;
      upd_q   <= 1'b0;
      idx_q   <= 3'd0;
      hold_q  <= '0;
      field_q <= 2'd0;
      bit_q   <= 3'd0;
      sh_q    <= '0;
      min_s_q <= '0;
      sec_s_q <= '0;
      oor_q   <= '0;
      for (int i = 0; i < 6; i++) begin
        disp_q[i] <= '0;
        shad_q[i] <= '0;
      end
    end else begin
      an_q  <= ~(6'b100000 >> idx_q);
      dp_q  <= ~((idx_q == 3'd1) || (idx_q == 3'd3));
      if (BLANK_LEAD_HR && idx_q == 3'd0 && dig == 4'd0) seg_q <= 7'b1111111;
      else                                               seg_q <= seg_code(dig);
      upd_q <= (state_q == C_COMMIT);

      if (hold_q == HW'(DIGIT_HOLD - 1)) begin
        hold_q <= '0;
        idx_q  <= (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
      end else begin
        hold_q <= hold_q + 1'b1;
      end

      case (state_q)
        C_LOAD: begin
          sh_q    <= {7'd0, 1'b0, hr};
          min_s_q <= min;
          sec_s_q <= sec;
          oor_q   <= {sec > 6'd59, min > 6'd59, hr > 5'd23};
          field_q <= 2'd0;
          bit_q   <= 3'd0;
        end
        C_SHIFT: begin
          if (bit_q == 3'd5) begin
            shad_q[{field_q, 1'b0}] <= oor_q[field_q] ? DASH : {1'b0, sh_next[12:10]};
            shad_q[{field_q, 1'b1}] <= oor_q[field_q] ? DASH : sh_next[9:6];
            sh_q    <= {7'd0, next_bin};
            field_q <= field_q + 2'd1;
            bit_q   <= 3'd0;
          end else begin
            sh_q  <= sh_next;
            bit_q <= bit_q + 3'd1;
          end
        end
        C_COMMIT: begin
          for (int i = 0; i < 6; i++) disp_q[i] <= shad_q[i];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_time_disp_scan.sv
// Directed bench for time_disp_scan: two instances (hold 1 with lead blank, hold 2 without)
// share inputs; cyc counts edges since the last reset release.
module tb_time_disp_scan;
  logic       kh_clk = 1'b0;
  logic       reset;
  logic [4:0] hr;
  logic [5:0] min, sec;
  logic [5:0] an_a, an_b;
  logic [6:0] seg_a, seg_b;
  logic       dp_a, dp_b, upd_a, upd_b;
  int checks = 0;
  int errors = 0;
  int cyc = -1;

  always #5 kh_clk = ~kh_clk;

  time_disp_scan #(.DIGIT_HOLD(1), .BLANK_LEAD_HR(1'b1)) dut_a (
    .kh_clk(kh_clk), .reset(reset), .hr(hr), .min(min), .sec(sec),
    .an(an_a), .seg(seg_a), .dp(dp_a), .upd(upd_a));

  time_disp_scan #(.DIGIT_HOLD(2), .BLANK_LEAD_HR(1'b0)) dut_b (
    .kh_clk(kh_clk), .reset(reset), .hr(hr), .min(min), .sec(sec),
    .an(an_b), .seg(seg_b), .dp(dp_b), .upd(upd_b));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %b expected %b", tag, cyc, got, exp);
    end
  endtask

  task automatic step();
    @(posedge kh_clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) step();
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    for (int i = 0; i < n; i++) begin
      step();
      chk("rst_an", an_a, 6'b111111);
      chk("rst_seg", seg_a, 7'b1111111);
      chk("rst_dp", dp_a, 1'b1);
      chk("rst_upd", upd_a, 1'b0);
      chk("rst_an_b", an_b, 6'b111111);
    end
    reset = 1'b0;
    cyc = -1;
  endtask

  // exp holds idx0 segments in the top 7 bits down to idx5 in the bottom 7
  task automatic chk_frame(input logic [41:0] exp);
    logic [5:0] an_e;
    for (int i = 0; i < 6; i++) begin
      step();
      an_e = ~(6'b100000 >> i);
      chk($sformatf("an_idx%0d", i), an_a, an_e);
      chk($sformatf("seg_idx%0d", i), seg_a, exp[41-7*i -: 7]);
      chk($sformatf("dp_idx%0d", i), dp_a, (i == 1 || i == 3) ? 1'b0 : 1'b1);
    end
  endtask

  initial begin
    reset = 1'b1;
    hr = 5'd13; min = 6'd45; sec = 6'd7;
    do_reset(3);

    run_to(19); chk("upd_pre", upd_a, 1'b0);
    run_to(20); chk("upd_commit", upd_a, 1'b1); chk("upd_commit_b", upd_b, 1'b1);
    run_to(21); chk("upd_post", upd_a, 1'b0);

    run_to(23);
    chk_frame({7'b1111001, 7'b0110000, 7'b0011001, 7'b0010010, 7'b1000000, 7'b1111000});

    // hold-2 instance: each digit stays for two cycles
    run_to(30); chk("b_an30", an_b, 6'b111011); chk("b_seg30", seg_b, 7'b0010010);
    run_to(31); chk("b_an31", an_b, 6'b111011);
    run_to(32); chk("b_an32", an_b, 6'b111101); chk("b_seg32", seg_b, 7'b1000000);
    run_to(33); chk("b_an33", an_b, 6'b111101);

    hr = 5'd5; min = 6'd60; sec = 6'd63;
    run_to(71);
    chk_frame({7'b1111111, 7'b0010010, 7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111});
    run_to(84); chk("b_an84", an_b, 6'b011111); chk("b_noblank", seg_b, 7'b1000000);
    run_to(86); chk("b_hr_units", seg_b, 7'b0010010);

    hr = 5'd10; min = 6'd0; sec = 6'd0;
    run_to(102);
    hr = 5'd22;
    run_to(116); chk("upd_116", upd_a, 1'b1);
    run_to(119);
    chk_frame({7'b1111001, 7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000});
    run_to(143);
    chk_frame({7'b0100100, 7'b0100100, 7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000});

    // abort a conversion 10 cycles after its start at edge 144
    run_to(153);
    hr = 5'd0; min = 6'd0; sec = 6'd0;
    do_reset(2);
    chk_frame({7'b1111111, 7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000});
    run_to(20); chk("upd_after_abort", upd_a, 1'b1);
    run_to(23);
    chk_frame({7'b1111111, 7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
